pmem_line_responder: RTL and testbench

- Synthesizable responder for the 256-bit cache-line physical-memory interface (pmem_read/pmem_write/pmem_address/pmem_wdata/pmem_resp/pmem_rdata).
- Sits on the memory side of the cache and answers line reads and writes after a fixed latency.
- Replaces the behavioural memory model on FPGA builds and gives a cycle-exact responder for cache verification.

---
 rtl/pmem_line_responder.sv | 119 +++++++++++
 tb/tb_pmem_line_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pmem_line_responder.sv
`timescale 1ns/1ps
// Fixed-latency 256-bit line responder for the cache pmem interface.
// Define PMEM_LINE_RESPONDER_STATS_EN to add the rd_count/wr_count completion counters.
module pmem_line_responder #(
  parameter int unsigned LINE_IDX_W = 4,
  parameter int unsigned LATENCY    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [255:0] pmem_rdata,
  output logic         error
`ifdef PMEM_LINE_RESPONDER_STATS_EN
  ,
  output logic [31:0]  rd_count,
  output logic [31:0]  wr_count
`endif
);

  localparam int unsigned DEPTH = 1 << LINE_IDX_W;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state, state_nx;
  logic [3:0]              cnt;
  logic                    rd_q, wr_q, in_range_q;
  logic [26:0]             addr_q;
  logic [255:0]            wdata_q;
  logic [255:0]            mem [DEPTH];
  logic [LINE_IDX_W-1:0]   idx_q;
  logic                    accept, in_range, accept_err, busy_err;
  logic                    wr_en, rd_done;
  logic                    unused_addr_bits;

  always_comb begin
    unused_addr_bits = ^pmem_address[4:0];
    idx_q      = addr_q[LINE_IDX_W-1:0];
    in_range   = (pmem_address[31:LINE_IDX_W+5] == '0);
    accept     = (state == IDLE) && (pmem_read || pmem_write);
    accept_err = accept && ((pmem_read && pmem_write) || !in_range);
    // Any change of the held request while busy, including withdrawal, is a protocol error.
    busy_err   = (state == BUSY) &&
                 ((pmem_read != rd_q) || (pmem_write != wr_q) ||
                  (pmem_address[31:5] != addr_q) || !(pmem_read || pmem_write));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pmem_read || pmem_write) state_nx = BUSY;
      BUSY:    if (cnt == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pmem_resp  = (state == BUSY) && (cnt == '0);
    pmem_rdata = '0;
    if (pmem_resp && rd_q && in_range_q) pmem_rdata = mem[idx_q];
    // Read wins when both requests were latched; out-of-range writes are dropped.
    wr_en      = pmem_resp && !rd_q && in_range_q;
    rd_done    = pmem_resp && rd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      in_range_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      error      <= 1'b0;
    end else begin
      if (accept) begin
        rd_q       <= pmem_read;
        wr_q       <= pmem_write;
        addr_q     <= pmem_address[31:5];
        wdata_q    <= pmem_wdata;
        in_range_q <= in_range;
        cnt        <= 4'(LATENCY - 1);
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - 4'd1;
      end
      error <= error | accept_err | busy_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[idx_q] <= wdata_q;
    end
  end

`ifdef PMEM_LINE_RESPONDER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_done && (rd_count != '1)) rd_count <= rd_count + 32'd1;
      if (wr_en && (wr_count != '1))   wr_count <= wr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for pmem_line_responder: driver pushes expected responses,
// a negedge monitor pops and compares data, response cycle and error flag.
module tb_pmem_line_responder;

  localparam int unsigned LIDX  = 4;
  localparam int unsigned L     = 4;
  localparam int unsigned DEPTH = 1 << LIDX;

  typedef struct {
    logic [255:0] rdata;
    int unsigned  cyc;
    logic         err;
  } exp_t;

  logic         clk, rst;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;
  logic         error;
`ifdef PMEM_LINE_RESPONDER_STATS_EN
  logic [31:0]  rd_count, wr_count;
`endif

  pmem_line_responder #(.LINE_IDX_W(LIDX), .LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .error(error)
`ifdef PMEM_LINE_RESPONDER_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  int unsigned  cyc = 0;
  bit           mon_en = 0;
  exp_t         exp_q[$];
  exp_t         e;

  // reference model state
  logic [255:0] mem_m [DEPTH];
  logic         err_m;
  int unsigned  rd_m, wr_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pmem_resp) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp at cyc %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          checks += 3;
          if (pmem_rdata !== e.rdata) begin
            errors++;
            $display("FAIL rdata got %h exp %h", pmem_rdata, e.rdata);
          end
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL resp_cycle got %0d exp %0d", cyc, e.cyc);
          end
          if (error !== e.err) begin
            errors++;
            $display("FAIL error_flag got %b exp %b", error, e.err);
          end
        end
      end else begin
        checks++;
        if (pmem_rdata !== '0) begin
          errors++;
          $display("FAIL rdata_idle got %h exp 0", pmem_rdata);
        end
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    err_m = 1'b0;
    rd_m  = 0;
    wr_m  = 0;
  endtask

  // pert: 0 none, 1 address change in BUSY, 2 request withdrawn in BUSY
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [255:0] wd, input int pert, input int gap);
    exp_t        x;
    bit          oor, got;
    int unsigned idx, acc;
    oor = (addr >> (LIDX + 5)) != 0;
    idx = (addr >> 5) % DEPTH;
    if ((rd && wr) || oor || pert != 0) err_m = 1'b1;
    x.rdata = (rd && !oor) ? mem_m[idx] : '0;
    if (rd) rd_m++;
    else if (!oor) begin
      mem_m[idx] = wd;
      wr_m++;
    end
    x.err = err_m;
    @(negedge clk);
    pmem_read = rd; pmem_write = wr; pmem_address = addr; pmem_wdata = wd;
    acc   = cyc + 1;
    x.cyc = acc + L - 1;
    exp_q.push_back(x);
    got = 0;
    for (int n = 0; n < L + 4 && !got; n++) begin
      @(negedge clk);
      if (pert == 1 && cyc == acc + 1) pmem_address = addr ^ 32'h20;
      if (pert == 2 && cyc == acc + 1) begin pmem_read = 0; pmem_write = 0; end
      if (pmem_resp) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL resp_timeout addr %h got none exp resp", addr);
    end
    @(negedge clk);
    pmem_read = 0; pmem_write = 0; pmem_address = '0; pmem_wdata = '0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic rand_phase(input int n, input bit allow_err);
    logic [31:0]  a;
    logic [255:0] wd;
    int           op, pert;
    for (int k = 0; k < n; k++) begin
      op = $urandom_range(0, 9);
      a  = {23'd0, 4'($urandom_range(0, DEPTH - 1)), 5'($urandom)};
      for (int i = 0; i < 8; i++) wd[i*32 +: 32] = $urandom();
      pert = 0;
      if (allow_err) begin
        if ($urandom_range(0, 9) == 0) a[$urandom_range(LIDX + 5, 31)] = 1'b1;
        if ($urandom_range(0, 9) == 0) pert = $urandom_range(1, 2);
      end else if (op == 8) op = 0;
      issue(op < 4 || op == 8, op >= 4, a, wd, pert, $urandom_range(0, 2));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; pmem_read = 0; pmem_write = 0; pmem_address = '0; pmem_wdata = '0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    checks += 3;
    if (pmem_resp !== 1'b0) begin errors++; $display("FAIL reset_resp got %b exp 0", pmem_resp); end
    if (pmem_rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h exp 0", pmem_rdata); end
    if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", error); end
    mon_en = 1;

    issue(1, 0, 32'h0000_0040, '0, 0, 0);
    issue(0, 1, 32'h0000_0060, {8{32'hDEAD_BEEF}}, 0, 0);
    issue(1, 0, 32'h0000_007F, '0, 0, 0);
    rand_phase(30, 0);
    issue(1, 0, 32'h0000_0200, '0, 0, 1);
    issue(1, 1, 32'h0000_0020, '1, 0, 0);
    issue(1, 0, 32'h0000_0020, '0, 0, 0);
    issue(0, 1, 32'h0000_0400, '1, 0, 0);
    issue(1, 0, 32'h0000_0040, '0, 1, 0);
    issue(0, 1, 32'h0000_00A0, {8{32'h1234_5678}}, 2, 0);
    rand_phase(30, 1);
    repeat (3) @(negedge clk);

`ifdef PMEM_LINE_RESPONDER_STATS_EN
    checks += 2;
    if (rd_count !== 32'(rd_m)) begin errors++; $display("FAIL rd_count got %0d exp %0d", rd_count, rd_m); end
    if (wr_count !== 32'(wr_m)) begin errors++; $display("FAIL wr_count got %0d exp %0d", wr_count, wr_m); end
`endif

    // reset in the middle of a pending read: no response may follow
    @(negedge clk);
    pmem_read = 1; pmem_address = 32'h0000_0060;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0; pmem_read = 0; pmem_address = '0;
    model_clear();
    repeat (L + 3) @(negedge clk);
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL error_after_rst got %b exp 0", error); end
`ifdef PMEM_LINE_RESPONDER_STATS_EN
    checks += 2;
    if (rd_count !== '0) begin errors++; $display("FAIL rd_count_rst got %0d exp 0", rd_count); end
    if (wr_count !== '0) begin errors++; $display("FAIL wr_count_rst got %0d exp 0", wr_count); end
`endif
    for (int i = 0; i < DEPTH; i++) issue(1, 0, 32'(i * 32), '0, 0, 0);
    repeat (3) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_resp got %0d left exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
